// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks registers with outstanding loads,
// detects RAW and structural hazards, and drives pipeline stall/flush controls.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned MAX_OUT  = 4,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned RW      = $clog2(NUM_REGS),
   localparam int unsigned PW      = $clog2(MAX_OUT + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            id_ex_mem_read_i,
   input  logic [RW-1:0]   id_ex_rd_i,
   input  logic [RW-1:0]   if_id_rs1_i,
   input  logic [RW-1:0]   if_id_rs2_i,
   input  logic            if_id_uses_rs1_i,
   input  logic            if_id_uses_rs2_i,
   input  logic            if_id_mem_read_i,
   input  logic            ex_branch_taken_i,
   input  logic            mem_resp_valid_i,
   input  logic [RW-1:0]   mem_resp_rd_i,
   output logic            pc_write_o,
   output logic            if_id_write_o,
   output logic            if_id_flush_o,
   output logic            id_ex_flush_o,
   output logic [CNT_W-1:0] stall_count_o,
   output logic [PW-1:0]   pending_count_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [PW-1:0]       pending_q, pending_d;
   logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

   logic issue, resp, inc, dec;
   logic raw1, raw2, struct_hz, stall;

   // Classify this cycle's issue/response events against the busy table.
   always_comb begin
      issue = id_ex_mem_read_i && (id_ex_rd_i != '0);
      resp  = mem_resp_valid_i && busy_q[mem_resp_rd_i];
      // A new busy register adds one; a response frees one unless the same register is re-set.
      inc   = issue && !busy_q[id_ex_rd_i];
      dec   = resp && !(issue && (id_ex_rd_i == mem_resp_rd_i));
   end

   // Hazard detection; a same-cycle response counts as forwarded data.
   always_comb begin
      raw1 = if_id_uses_rs1_i && (if_id_rs1_i != '0) &&
             ((busy_q[if_id_rs1_i] && !(mem_resp_valid_i && (mem_resp_rd_i == if_id_rs1_i))) ||
              (issue && (id_ex_rd_i == if_id_rs1_i)));
      raw2 = if_id_uses_rs2_i && (if_id_rs2_i != '0) &&
             ((busy_q[if_id_rs2_i] && !(mem_resp_valid_i && (mem_resp_rd_i == if_id_rs2_i))) ||
              (issue && (id_ex_rd_i == if_id_rs2_i)));
      struct_hz = if_id_mem_read_i && (pending_q == PW'(MAX_OUT)) && !resp;
      stall     = raw1 || raw2 || struct_hz;
   end

   // Next-state for busy table, pending count and stall counter.
   always_comb begin
      busy_d = busy_q;
      if (resp) begin
         busy_d[mem_resp_rd_i] = 1'b0;
      end
      if (issue) begin
         busy_d[id_ex_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;

      pending_d = pending_q + PW'(inc) - PW'(dec);

      stall_cnt_d = stall_cnt_q;
      if (stall && !ex_branch_taken_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q      <= '0;
         pending_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_q      <= busy_d;
         pending_q   <= pending_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Pipeline control: a taken branch overrides any stall.
   always_comb begin
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      if (ex_branch_taken_i) begin
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
      end else if (stall) begin
         pc_write_o    = 1'b0;
         if_id_write_o = 1'b0;
         id_ex_flush_o = 1'b1;
      end
   end

   assign stall_count_o   = stall_cnt_q;
   assign pending_count_o = pending_q;

endmodule
